serial_sub: RTL and testbench

//  Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.

---
 rtl/serial_sub.sv | 138 +++++++++++++
 tb/tb_serial_sub.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first, start/busy/done handshake.
// Define SUB_OVF_EN to add the signed-overflow output ovf.
module serial_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             d_bit, br_nxt;
`ifdef SUB_OVF_EN
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;
    logic             ovf_q, ovf_d;
`endif

    // One full-subtractor cell, reused every RUN cycle on the operand LSBs.
    assign d_bit  = a_q[0] ^ b_q[0] ^ br_q;
    assign br_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
`ifdef SUB_OVF_EN
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
`ifdef SUB_OVF_EN
                    amsb_d  = a[WIDTH-1];
                    bmsb_d  = b[WIDTH-1];
`endif
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = (res_q >> 1) | {d_bit, {(WIDTH-1){1'b0}}};
                br_d  = br_nxt;
                cnt_d = cnt_q + CW'(1);
                // Results are published only on the last bit so diff/bout hold during RUN.
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = DONE;
                    diff_d  = res_d;
                    bout_d  = br_nxt;
`ifdef SUB_OVF_EN
                    ovf_d   = (amsb_q != bmsb_q) && (d_bit != amsb_q);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
`ifdef SUB_OVF_EN
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
`ifdef SUB_OVF_EN
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Bench for serial_sub: directed literal cases plus random traffic against a phase-counter reference model.
// Build with SUB_OVF_EN defined to also check ovf.
module tb_serial_sub;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         bin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, bout;
    logic [W-1:0] diff;
`ifdef SUB_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    task automatic check(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1..W busy, W+1 done; result computed arithmetically at accept.
    int m_phase = 0;
    int m_diff = 0, m_bout = 0, m_ovf = 0;
    int p_diff = 0, p_bout = 0, p_ovf = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0; m_diff = 0; m_bout = 0; m_ovf = 0;
        end else if ((m_phase == 0 || m_phase == W + 1) && start) begin
            p_diff  = (int'(a) - int'(b) - int'(bin)) & ((1 << W) - 1);
            p_bout  = (int'(a) < int'(b) + int'(bin)) ? 1 : 0;
            p_ovf   = ((a[W-1] != b[W-1]) && (p_diff[W-1] != a[W-1])) ? 1 : 0;
            m_phase = 1;
        end else if (m_phase >= 1 && m_phase <= W) begin
            m_phase++;
            if (m_phase == W + 1) begin
                m_diff = p_diff; m_bout = p_bout; m_ovf = p_ovf;
            end
        end else begin
            m_phase = 0;
        end
    end

    always @(negedge clk) begin
        check("busy", int'(busy), (m_phase >= 1 && m_phase <= W) ? 1 : 0);
        check("done", int'(done), (m_phase == W + 1) ? 1 : 0);
        if (!(m_phase >= 1 && m_phase <= W)) begin
            check("diff", int'(diff), m_diff);
            check("bout", int'(bout), m_bout);
`ifdef SUB_OVF_EN
            check("ovf", int'(ovf), m_ovf);
`endif
        end
    end

    task automatic do_op(input int av, input int bv, input int bi,
                         input int ed, input int ebo, input int eov);
        int n, nb;
        @(negedge clk);
        a = W'(av); b = W'(bv); bin = bi[0]; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        n = 1; nb = 0;
        while (!done && n < 20) begin
            if (busy) nb++;
            @(negedge clk);
            n++;
        end
        check("op_done_seen", int'(done), 1);
        check("op_latency", n, W + 1);
        check("op_busy_cycles", nb, W);
        check("op_diff", int'(diff), ed);
        check("op_bout", int'(bout), ebo);
`ifdef SUB_OVF_EN
        check("op_ovf", int'(ovf), eov);
`else
        if (eov < 0) check("op_ovf_arg", eov, 0);
`endif
    endtask

    initial begin
        int n, pulses;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_diff", int'(diff), 0);
        check("rst_bout", int'(bout), 0);
        rst_n = 1'b1;

        do_op(4'h7, 4'h3, 0, 4'h4, 0, 0);
        do_op(4'h3, 4'h7, 0, 4'hC, 1, 0);
        do_op(4'h0, 4'h0, 1, 4'hF, 1, 0);
        do_op(4'h6, 4'h6, 0, 4'h0, 0, 0);
        do_op(4'h8, 4'h1, 0, 4'h7, 0, 1);
        do_op(4'h6, 4'h2, 0, 4'h4, 0, 0);

        // Back-to-back with start held high through DONE.
        @(negedge clk);
        a = 4'd9; b = 4'd2; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 4'd5; b = 4'd5;
        n = 1;
        while (!done && n < 20) begin @(negedge clk); n++; end
        check("b2b_first_latency", n, W + 1);
        check("b2b_first_diff", int'(diff), 7);
        check("b2b_first_bout", int'(bout), 0);
        n = 0;
        do begin @(negedge clk); n++; end while (!done && n < 20);
        start = 1'b0;
        check("b2b_spacing", n, W + 1);
        check("b2b_second_diff", int'(diff), 0);
        check("b2b_second_bout", int'(bout), 0);
        @(negedge clk);

        // Start mid-RUN must be ignored.
        @(negedge clk);
        a = 4'hA; b = 4'h5; bin = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); a = 4'h1; b = 4'h1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                pulses++;
                check("ign_diff", int'(diff), 5);
                check("ign_bout", int'(bout), 0);
            end
            @(negedge clk);
        end
        check("ign_pulses", pulses, 1);

        // Reset at cnt=2 aborts the operation.
        a = 4'hF; b = 4'h1; bin = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_diff", int'(diff), 0);
        check("abort_bout", int'(bout), 0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        check("abort_no_done", pulses, 0);
        do_op(4'hB, 4'h4, 1, 4'h6, 0, 1);

        // Random traffic, checked every cycle by the compare process.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            a     = W'($urandom);
            b     = W'($urandom);
            bin   = 1'($urandom);
            start = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 59) != 0);
        end
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;
        repeat (W + 3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
